// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Control unit for the multicycle MIPS core. A Moore main FSM steps each
// instruction through fetch, decode, execute, memory and writeback cycles and
// drives every datapath mux select and write enable. An ALU decoder combines
// the FSM's ALU op with the instruction funct field to form the ALU control
// code.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   op         in   6  instruction[31:26] from the instruction register
//   funct      in   6  instruction[5:0] from the instruction register
//   zero       in   1  ALU zero flag
//   pcen       out  1  PC register enable
//   memwrite   out  1  memory write strobe
//   irwrite    out  1  instruction register enable
//   regwrite   out  1  register file write enable
//   alusrca    out  1  ALU A select: 0 = PC, 1 = register A
//   alusrcb    out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
//   iord       out  1  memory address select: 0 = PC, 1 = ALUOut
//   memtoreg   out  1  register write data: 0 = ALUOut, 1 = Data
//   regdst     out  1  destination register: 0 = rt, 1 = rd
//   pcsrc      out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   alucontrol out  3  ALU function code
//   state      out  4  current FSM state (debug)
//
// All outputs are decoded combinationally from the state register; pcen
// additionally depends on zero and alucontrol on funct. The four write
// enables are masked while reset is high so an aborted instruction cannot
// write anything during the reset cycle(s).
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q;
  state_e state_d;

  // Raw per-state controls, before reset masking.
  logic       pcwrite_s;
  logic       branch_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic       iord_s;
  logic       memtoreg_s;
  logic       regdst_s;
  logic [1:0] pcsrc_s;
  logic [1:0] aluop_s;
  logic [2:0] alucontrol_s;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; undefined opcodes and encodings 12-15 fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_RTYPEEX;
          OP_BEQ:   state_d = S_BEQEX;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JEX;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // Only lw and sw reach MEMADR; anything other than lw is the store path.
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; every field not set by a state stays 0.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    pcsrc_s    = 2'b00;
    aluop_s    = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb_s = 2'b01;
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrcb_s = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: begin
        iord_s = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b01;
        pcsrc_s   = 2'b01;
        branch_s  = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
      end
      S_JEX: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        // Unreachable encodings: everything stays at its inactive value.
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // ALU decoder: aluop selects add/sub directly or defers to funct.
  always_comb begin
    alucontrol_s = ALU_ADD;
    case (aluop_s)
      2'b00: alucontrol_s = ALU_ADD;
      2'b01: alucontrol_s = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol_s = ALU_ADD;
          6'b100010: alucontrol_s = ALU_SUB;
          6'b100100: alucontrol_s = ALU_AND;
          6'b100101: alucontrol_s = ALU_OR;
          6'b101010: alucontrol_s = ALU_SLT;
          default:   alucontrol_s = ALU_ADD;
        endcase
      end
      default: alucontrol_s = ALU_ADD;
    endcase
  end

  // Enables are gated by reset so an interrupted instruction writes nothing.
  assign pcen       = (pcwrite_s | (branch_s & zero)) & ~reset;
  assign memwrite   = memwrite_s & ~reset;
  assign irwrite    = irwrite_s & ~reset;
  assign regwrite   = regwrite_s & ~reset;
  assign alusrca    = alusrca_s;
  assign alusrcb    = alusrcb_s;
  assign iord       = iord_s;
  assign memtoreg   = memtoreg_s;
  assign regdst     = regdst_s;
  assign pcsrc      = pcsrc_s;
  assign alucontrol = alucontrol_s;
  assign state      = state_q;

endmodule
